// File: rtl/hpdmc_dqsched.sv
// Write-data-path scheduler for the HPDMC DDR32 PHY: a slot wheel of future data beats
// drives DQ/DQS enables and the write-data fetch, and gates write/read issue for spacing.
module hpdmc_dqsched #(
  parameter int BURST_LEN = 4,
  parameter int WR_DELAY  = 2,
  parameter int WTR       = 2,
  parameter int RTW       = 3
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst,
  input  logic i_write,
  input  logic i_read,
  output logic o_write_safe,
  output logic o_read_safe,
  output logic o_fetch,
  output logic o_dq_oe,
  output logic o_dqs_oe,
  output logic o_dqs_toggle,
  output logic o_cmd_err
);

  localparam int L = WR_DELAY + BURST_LEN;
  localparam logic [L-1:0] W_MASK = L'({BURST_LEN{1'b1}}) << WR_DELAY;

  logic [L-1:0] r_wheel;
  logic         r_post;
  logic [2:0]   r_wtr;
  logic [2:0]   r_rtw;
  logic         r_err;

  logic         w_write_safe;
  logic         w_read_safe;
  logic         w_wr_acc;
  logic         w_rd_acc;
  logic [L-1:0] w_wheel_or;

  assign w_write_safe = ~r_wheel[WR_DELAY] & (r_rtw == 3'd0);
  assign w_read_safe  = (r_wheel == '0) & ~r_post & (r_wtr == 3'd0);
  assign w_wr_acc     = i_write & w_write_safe;
  // On a simultaneous idle write+read the write wins and the read is flagged.
  assign w_rd_acc     = i_read & w_read_safe & ~w_wr_acc;
  assign w_wheel_or   = r_wheel | (w_wr_acc ? W_MASK : '0);

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_wheel <= '0;
      r_post  <= 1'b0;
      r_wtr   <= 3'd0;
      r_rtw   <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      r_wheel <= w_wheel_or >> 1;
      r_post  <= r_wheel[0] & ~r_wheel[1];
      // Turnaround count starts after the postamble so WTR idle cycles follow it.
      if (r_wheel[0] | r_post)
        r_wtr <= 3'(WTR);
      else if (r_wtr != 3'd0)
        r_wtr <= r_wtr - 3'd1;
      if (w_rd_acc)
        r_rtw <= 3'(RTW);
      else if (r_rtw != 3'd0)
        r_rtw <= r_rtw - 3'd1;
      r_err <= r_err | (i_write & ~w_write_safe) | (i_read & ~w_rd_acc);
    end
  end

  assign o_write_safe = w_write_safe;
  assign o_read_safe  = w_read_safe;
  assign o_fetch      = r_wheel[0];
  assign o_dq_oe      = r_wheel[0];
  assign o_dqs_toggle = r_wheel[0];
  assign o_dqs_oe     = r_wheel[0] | r_wheel[1] | r_post;
  assign o_cmd_err    = r_err;

endmodule

// File: tb/tb_hpdmc_dqsched.sv
// Scoreboard bench for hpdmc_dqsched: expected fetch cycles are queued when writes are
// driven and retired as fetch pulses appear; enables and safety flags checked per cycle.
module tb_hpdmc_dqsched;

  logic clk = 1'b0;
  logic rst;
  logic wr, rd, wr_b, rd_b;
  logic ws, rs, fetch, dq_oe, dqs_oe, tog, err;
  logic b_ws, b_rs, b_fetch, b_dq_oe, b_dqs_oe, b_tog, b_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_fetch = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  hpdmc_dqsched dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_write(wr), .i_read(rd),
    .o_write_safe(ws), .o_read_safe(rs), .o_fetch(fetch), .o_dq_oe(dq_oe),
    .o_dqs_oe(dqs_oe), .o_dqs_toggle(tog), .o_cmd_err(err)
  );

  hpdmc_dqsched #(.BURST_LEN(1), .WR_DELAY(1), .WTR(0), .RTW(3)) dut_b (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_write(wr_b), .i_read(rd_b),
    .o_write_safe(b_ws), .o_read_safe(b_rs), .o_fetch(b_fetch), .o_dq_oe(b_dq_oe),
    .o_dqs_oe(b_dqs_oe), .o_dqs_toggle(b_tog), .o_cmd_err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Queue the fetch cycles an accepted default-parameter write must produce.
  task automatic push_wr(input int n, input int beats);
    for (int i = 0; i < beats; i++) exp_q.push_back(n + 2 + i);
  endtask

  task automatic mon();
    if (fetch === 1'b1) begin
      n_fetch++;
      if (exp_q.size() == 0) chk("fetch_extra", cyc, -1);
      else chk("fetch_cyc", cyc, exp_q.pop_front());
    end
  endtask

  task automatic step();
    mon();
    @(posedge clk);
    #1;
    cyc++;
    wr = 1'b0; rd = 1'b0; wr_b = 1'b0; rd_b = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0; wr_b = 1'b0; rd_b = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    n_fetch = 0;
    exp_q.delete();
  endtask

  task automatic end_test(input string tag, input int fetches);
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_nfetch"}, n_fetch, fetches);
  endtask

  initial begin
    do_reset();
    chk("rst_fetch", fetch, 0);
    chk("rst_dq_oe", dq_oe, 0);
    chk("rst_dqs_oe", dqs_oe, 0);
    chk("rst_toggle", tog, 0);
    chk("rst_wsafe", ws, 1);
    chk("rst_rsafe", rs, 1);
    chk("rst_err", err, 0);

    // Single write in cycle 10.
    while (cyc <= 22) begin
      if (cyc == 10) begin wr = 1'b1; push_wr(10, 4); end
      chk("t1_dqs_oe", dqs_oe, (cyc >= 11 && cyc <= 16));
      chk("t1_dq_oe", dq_oe, (cyc >= 12 && cyc <= 15));
      chk("t1_toggle", tog, (cyc >= 12 && cyc <= 15));
      if (cyc >= 11) chk("t1_rsafe", rs, !(cyc <= 18));
      step();
    end
    chk("t1_err", err, 0);
    end_test("t1", 4);

    // Back-to-back writes merge.
    do_reset();
    while (cyc <= 24) begin
      if (cyc == 10) begin wr = 1'b1; push_wr(10, 4); end
      if (cyc == 14) begin wr = 1'b1; push_wr(14, 4); end
      if (cyc >= 10) begin
        chk("t2_dq_oe", dq_oe, (cyc >= 12 && cyc <= 19));
        chk("t2_dqs_oe", dqs_oe, (cyc >= 11 && cyc <= 20));
      end
      step();
    end
    chk("t2_err", err, 0);
    end_test("t2", 8);

    // Overlapping write is rejected.
    do_reset();
    while (cyc <= 20) begin
      if (cyc == 10) begin wr = 1'b1; push_wr(10, 4); end
      if (cyc == 12) wr = 1'b1;
      if (cyc == 12) chk("t3_err_pre", err, 0);
      if (cyc == 13) chk("t3_err", err, 1);
      step();
    end
    end_test("t3", 4);

    // Read-to-write turnaround.
    do_reset();
    while (cyc <= 20) begin
      if (cyc == 5) begin chk("t4_rsafe", rs, 1); rd = 1'b1; end
      if (cyc >= 6 && cyc <= 9) chk("t4_wsafe", ws, (cyc == 9));
      if (cyc == 7) wr = 1'b1;
      if (cyc == 7) chk("t4_err_pre", err, 0);
      if (cyc == 8) chk("t4_err", err, 1);
      if (cyc == 9) begin wr = 1'b1; exp_q.push_back(11); exp_q.push_back(12);
                          exp_q.push_back(13); exp_q.push_back(14); end
      step();
    end
    end_test("t4", 4);

    // Reset mid-burst aborts it.
    do_reset();
    while (cyc <= 20) begin
      if (cyc == 10) begin wr = 1'b1; exp_q.push_back(12); exp_q.push_back(13); end
      if (cyc == 11) wr = 1'b1;
      if (cyc == 12) chk("t5_err_set", err, 1);
      if (cyc == 13) rst = 1'b1;
      if (cyc == 14) begin
        chk("t5_dq_oe", dq_oe, 0);
        chk("t5_dqs_oe", dqs_oe, 0);
        chk("t5_toggle", tog, 0);
        chk("t5_wsafe", ws, 1);
        chk("t5_rsafe", rs, 1);
        chk("t5_err", err, 0);
      end
      step();
    end
    end_test("t5", 2);

    // Simultaneous write and read while idle: write wins, read flagged.
    do_reset();
    while (cyc <= 12) begin
      if (cyc == 3) begin wr = 1'b1; rd = 1'b1; push_wr(3, 4); end
      if (cyc == 4) chk("t6_err", err, 1);
      step();
    end
    end_test("t6", 4);

    // Minimum-latency instance: WR_DELAY=1, BURST_LEN=1, WTR=0.
    do_reset();
    while (cyc <= 9) begin
      if (cyc == 3) wr_b = 1'b1;
      if (cyc >= 4) begin
        chk("t7_dq_oe", b_dq_oe, (cyc == 4));
        chk("t7_fetch", b_fetch, (cyc == 4));
        chk("t7_dqs_oe", b_dqs_oe, (cyc <= 5));
        chk("t7_rsafe", b_rs, (cyc >= 6));
      end
      step();
    end
    chk("t7_err", b_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
